// File: rtl/red_pitaya_fads_pkg.sv
// Shared definitions for the FADS detector demultiplexer: channel-address width,
// default channel count and the dwell state encoding.
package red_pitaya_fads_pkg;

    localparam int unsigned CH_ADDR_W    = 3;
    localparam int unsigned CHNL_DEFAULT = 6;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StAccum,
        StDone
    } fads_state_e;

endpackage

// File: rtl/red_pitaya_boxcar_acc.sv
// Boxcar averager: sums 2^ACC_LOG2 sign-extended samples, pulses done_o the cycle after the
// last one and presents the sum scaled down by 2^ACC_LOG2 (floor) on sum_o.
module red_pitaya_boxcar_acc #(
    parameter int unsigned ADC_W    = 14,
    parameter int unsigned ACC_LOG2 = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [ADC_W-1:0] sample_i,
    output logic [ADC_W-1:0] sum_o,
    output logic             done_o
);

    localparam int unsigned SumW = ADC_W + ACC_LOG2;

    logic signed [SumW-1:0]     acc_q, acc_d;
    logic signed [SumW-1:0]     sample_ext;
    logic        [ACC_LOG2-1:0] cnt_q, cnt_d;
    logic                       done_q, done_d;

    assign sample_ext = SumW'($signed(sample_i));

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (enable_i) begin
            acc_d  = acc_q + sample_ext;
            cnt_d  = cnt_q + ACC_LOG2'(1);
            done_d = &cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Arithmetic shift floors toward minus infinity; the result always fits in ADC_W.
    assign sum_o  = ADC_W'(acc_q >>> ACC_LOG2);
    assign done_o = done_q;

endmodule

// File: rtl/red_pitaya_demux_acc.sv
// Demultiplexes a time-multiplexed ADC stream into per-channel dwell averages.
// Optional per-channel threshold detection is enabled by RED_PITAYA_DEMUX_DETECT_EN.
module red_pitaya_demux_acc
    import red_pitaya_fads_pkg::*;
#(
    parameter int unsigned CHNL     = CHNL_DEFAULT,
    parameter int unsigned ADC_W    = 14,
    parameter int unsigned ACC_LOG2 = 6
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic [CH_ADDR_W-1:0]  mux_addr_i,
    input  logic [ADC_W-1:0]      adc_dat_i,
    input  logic [7:0]            settle_i,
`ifdef RED_PITAYA_DEMUX_DETECT_EN
    input  logic [CHNL*ADC_W-1:0] thresh_i,
    output logic [CHNL-1:0]       det_o,
`endif
    output logic [ADC_W-1:0]      smp_dat_o,
    output logic [CH_ADDR_W-1:0]  smp_chn_o,
    output logic                  smp_vld_o,
    output logic [CHNL*ADC_W-1:0] ch_dat_o,
    output logic [CHNL-1:0]       ch_upd_o
);

    fads_state_e              state_q, state_d;
    logic [CH_ADDR_W-1:0]     addr_q;
    logic                     first_q;
    logic [7:0]               cnt_q, cnt_d;
    logic [ADC_W-1:0]         smp_dat_q, smp_dat_d;
    logic [CH_ADDR_W-1:0]     smp_chn_q, smp_chn_d;
    logic                     smp_vld_q, smp_vld_d;
    logic [CHNL*ADC_W-1:0]    ch_dat_q, ch_dat_d;
    logic [CHNL-1:0]          ch_upd_q, ch_upd_d;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
    logic [CHNL-1:0]          det_q, det_d;
`endif

    logic             change, in_range, acc_en, acc_done;
    logic [ADC_W-1:0] acc_avg;

    // The first edge after reset always counts as a change so address 0 gets a dwell.
    assign change   = first_q || (mux_addr_i != addr_q);
    assign in_range = 32'(mux_addr_i) < CHNL;
    assign acc_en   = !change && (((state_q == StSettle) && (cnt_q == 8'd0)) ||
                                  ((state_q == StAccum) && !acc_done));

    red_pitaya_boxcar_acc #(
        .ADC_W    (ADC_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_boxcar (
        .clk_i    (adc_clk_i),
        .rst_i    (adc_rstn_i),
        .clear_i  (change),
        .enable_i (acc_en),
        .sample_i (adc_dat_i),
        .sum_o    (acc_avg),
        .done_o   (acc_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        smp_dat_d = smp_dat_q;
        smp_chn_d = smp_chn_q;
        smp_vld_d = 1'b0;
        ch_dat_d  = ch_dat_q;
        ch_upd_d  = '0;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
        det_d     = det_q;
`endif
        if (change) begin
            state_d = in_range ? StSettle : StIdle;
            cnt_d   = in_range ? settle_i : 8'd0;
        end else begin
            unique case (state_q)
                StSettle: begin
                    if (cnt_q == 8'd0) begin
                        state_d = StAccum;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StAccum: begin
                    if (acc_done) begin
                        state_d   = StDone;
                        smp_vld_d = 1'b1;
                        smp_dat_d = acc_avg;
                        smp_chn_d = addr_q;
                        for (int unsigned k = 0; k < CHNL; k++) begin
                            if (addr_q == CH_ADDR_W'(k)) begin
                                ch_upd_d[k]                = 1'b1;
                                ch_dat_d[k*ADC_W +: ADC_W] = acc_avg;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
                                det_d[k] = $signed(acc_avg) > $signed(thresh_i[k*ADC_W +: ADC_W]);
`endif
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i or posedge adc_rstn_i) begin
        if (adc_rstn_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            first_q   <= 1'b1;
            cnt_q     <= '0;
            smp_dat_q <= '0;
            smp_chn_q <= '0;
            smp_vld_q <= 1'b0;
            ch_dat_q  <= '0;
            ch_upd_q  <= '0;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
            det_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= mux_addr_i;
            first_q   <= 1'b0;
            cnt_q     <= cnt_d;
            smp_dat_q <= smp_dat_d;
            smp_chn_q <= smp_chn_d;
            smp_vld_q <= smp_vld_d;
            ch_dat_q  <= ch_dat_d;
            ch_upd_q  <= ch_upd_d;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
            det_q     <= det_d;
`endif
        end
    end

    assign smp_dat_o = smp_dat_q;
    assign smp_chn_o = smp_chn_q;
    assign smp_vld_o = smp_vld_q;
    assign ch_dat_o  = ch_dat_q;
    assign ch_upd_o  = ch_upd_q;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
    assign det_o     = det_q;
`endif

endmodule

// File: tb/tb_red_pitaya_demux_acc.sv
// Directed bench for red_pitaya_demux_acc: table of dwells plus abort, out-of-range,
// reset and (with RED_PITAYA_DEMUX_DETECT_EN) detection sequences.
module tb_red_pitaya_demux_acc;

    localparam int unsigned CHNL  = 6;
    localparam int unsigned ADC_W = 14;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [2:0]            mux_addr_i = 3'd0;
    logic [ADC_W-1:0]      adc_dat_i = '0;
    logic [7:0]            settle_i = 8'd0;
    logic [ADC_W-1:0]      smp_dat_o;
    logic [2:0]            smp_chn_o;
    logic                  smp_vld_o;
    logic [CHNL*ADC_W-1:0] ch_dat_o;
    logic [CHNL-1:0]       ch_upd_o;
`ifdef RED_PITAYA_DEMUX_DETECT_EN
    logic [CHNL*ADC_W-1:0] thresh_i = '0;
    logic [CHNL-1:0]       det_o;
`endif

    red_pitaya_demux_acc #(
        .CHNL     (CHNL),
        .ADC_W    (ADC_W),
        .ACC_LOG2 (6)
    ) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rst),
        .mux_addr_i (mux_addr_i),
        .adc_dat_i  (adc_dat_i),
        .settle_i   (settle_i),
`ifdef RED_PITAYA_DEMUX_DETECT_EN
        .thresh_i   (thresh_i),
        .det_o      (det_o),
`endif
        .smp_dat_o  (smp_dat_o),
        .smp_chn_o  (smp_chn_o),
        .smp_vld_o  (smp_vld_o),
        .ch_dat_o   (ch_dat_o),
        .ch_upd_o   (ch_upd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       addr;
        logic [7:0]       settle;
        bit               alt;
        logic [ADC_W-1:0] val;
        logic [ADC_W-1:0] exp_dat;
    } vec_t;

    localparam logic [ADC_W-1:0] Junk = 14'h2AAA;

    int                    n_checks = 0;
    int                    n_err    = 0;
    logic [CHNL*ADC_W-1:0] exp_ch   = '0;
    logic [ADC_W-1:0]      last_dat = '0;
    logic [2:0]            last_chn = '0;
    vec_t                  vecs[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full dwell: change edge, settle_i blank edges (junk data), 64 samples, strobe.
    task automatic run_dwell(input string name, input logic [2:0] addr, input logic [7:0] settle,
                             input bit alt, input logic [ADC_W-1:0] val,
                             input logic [ADC_W-1:0] exp_dat);
        int n;
        bit early;
        n     = int'(settle) + 65;
        early = 1'b0;
        mux_addr_i = addr;
        settle_i   = settle;
        adc_dat_i  = Junk;
        @(posedge clk); #1;
        settle_i = 8'hA5;
        for (int k = 1; k <= n; k++) begin
            if (k > int'(settle) && k <= int'(settle) + 64)
                adc_dat_i = (alt && ((k - int'(settle)) % 2 == 0)) ? '0 : val;
            else
                adc_dat_i = Junk;
            @(posedge clk); #1;
            if (k < n && (smp_vld_o || ch_upd_o != '0)) early = 1'b1;
        end
        exp_ch[addr*ADC_W +: ADC_W] = exp_dat;
        last_dat = exp_dat;
        last_chn = addr;
        check({name, " early_strobe"}, 128'(early), 128'(0));
        check({name, " vld"}, 128'(smp_vld_o), 128'(1));
        check({name, " dat"}, 128'(smp_dat_o), 128'(exp_dat));
        check({name, " chn"}, 128'(smp_chn_o), 128'(addr));
        check({name, " upd"}, 128'(ch_upd_o), 128'(6'd1 << addr));
        check({name, " ch_dat"}, 128'(ch_dat_o), 128'(exp_ch));
        @(posedge clk); #1;
        check({name, " vld_single"}, 128'({smp_vld_o, ch_upd_o}), 128'(0));
        check({name, " dat_hold"}, 128'({smp_chn_o, smp_dat_o}), 128'({addr, exp_dat}));
    endtask

    initial begin
        bit seen;
        vecs[0] = '{3'd0, 8'd0,   1'b0, 14'd7,    14'd7};
        vecs[1] = '{3'd1, 8'd16,  1'b0, 14'd100,  14'd100};
        vecs[2] = '{3'd2, 8'd3,   1'b0, 14'h3FFD, 14'h3FFD};
        vecs[3] = '{3'd3, 8'd0,   1'b1, 14'h3FFF, 14'h3FFF};
        vecs[4] = '{3'd4, 8'd255, 1'b0, 14'h2000, 14'h2000};
        vecs[5] = '{3'd5, 8'd1,   1'b0, 14'h1FFF, 14'h1FFF};
        vecs[6] = '{3'd0, 8'd2,   1'b0, 14'h3F9C, 14'h3F9C};
        vecs[7] = '{3'd1, 8'd4,   1'b1, 14'd5,    14'd2};
        vecs[8] = '{3'd2, 8'd5,   1'b1, 14'h3FFB, 14'h3FFD};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({smp_dat_o, smp_chn_o, smp_vld_o, ch_dat_o, ch_upd_o}),
              128'(0));
        rst = 1'b0;

        foreach (vecs[i])
            run_dwell($sformatf("vec%0d", i), vecs[i].addr, vecs[i].settle, vecs[i].alt,
                      vecs[i].val, vecs[i].exp_dat);

        // Abort: 30 samples on channel 3, then move to channel 4.
        seen = 1'b0;
        mux_addr_i = 3'd3;
        settle_i   = 8'd2;
        adc_dat_i  = 14'd1000;
        repeat (33) begin
            @(posedge clk); #1;
            if (smp_vld_o || ch_upd_o != '0) seen = 1'b1;
        end
        check("abort no_strobe", 128'(seen), 128'(0));
        check("abort ch_dat", 128'(ch_dat_o), 128'(exp_ch));
        run_dwell("abort_next", 3'd4, 8'd10, 1'b0, 14'd50, 14'd50);

        // Out-of-range address parks the block.
        seen = 1'b0;
        mux_addr_i = 3'd7;
        settle_i   = 8'd0;
        adc_dat_i  = 14'd300;
        repeat (100) begin
            @(posedge clk); #1;
            if (smp_vld_o || ch_upd_o != '0) seen = 1'b1;
        end
        check("oor no_strobe", 128'(seen), 128'(0));
        check("oor hold", 128'({smp_chn_o, smp_dat_o, ch_dat_o}),
              128'({last_chn, last_dat, exp_ch}));
        run_dwell("oor_return", 3'd2, 8'd7, 1'b0, 14'd1234, 14'd1234);

        // Reset in the middle of an accumulation.
        mux_addr_i = 3'd5;
        settle_i   = 8'd0;
        adc_dat_i  = 14'd100;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst outputs", 128'({smp_dat_o, smp_chn_o, smp_vld_o, ch_dat_o, ch_upd_o}),
              128'(0));
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_ch = '0;
        run_dwell("after_rst", 3'd5, 8'd3, 1'b0, 14'd77, 14'd77);

`ifdef RED_PITAYA_DEMUX_DETECT_EN
        thresh_i[3*ADC_W +: ADC_W] = 14'd500;
        run_dwell("det_600", 3'd3, 8'd1, 1'b0, 14'd600, 14'd600);
        check("det3 above", 128'(det_o[3]), 128'(1));
        run_dwell("det_mid", 3'd1, 8'd1, 1'b0, 14'd9, 14'd9);
        check("det3 held", 128'(det_o[3]), 128'(1));
        run_dwell("det_500", 3'd3, 8'd1, 1'b0, 14'd500, 14'd500);
        check("det3 equal", 128'(det_o[3]), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
